fsm_cmd_sequencer: RTL



---
 rtl/fsm_cmd_sequencer_if.sv | 20 ++
 rtl/fsm_cmd_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/fsm_cmd_sequencer_if.sv
// fsm_cmd_sequencer_if: requester handshake, target command/status and response bundle for fsm_cmd_sequencer
interface fsm_cmd_sequencer_if;
  logic       req_valid;
  logic [2:0] req_cmd;
  logic       req_ready;
  logic [2:0] cmd_out;
  logic       cmd_strobe;
  logic [2:0] status_in;
  logic       rsp_valid;
  logic [1:0] rsp_state;
  logic [1:0] rsp_err;
  modport master (
    input  req_valid, req_cmd, status_in,
    output req_ready, cmd_out, cmd_strobe, rsp_valid, rsp_state, rsp_err
  );
  modport slave (
    output req_valid, req_cmd, status_in,
    input  req_ready, cmd_out, cmd_strobe, rsp_valid, rsp_state, rsp_err
  );
endinterface

// File: rtl/fsm_cmd_sequencer.sv
// fsm_cmd_sequencer: issues a 3-bit command, waits for the expected status with timeout/retry, one response per request; FSM_CMD_FILTER_EN rejects commands 6/7
module fsm_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input logic                 clk,
  input logic                 rst,
  fsm_cmd_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  state_t     state;
  logic [2:0] cmd_q;
  logic [7:0] tcnt;
  logic [2:0] rcnt;
  logic [1:0] exp_state;
  logic       exp_ok;
  logic       match;
  logic       last;
  logic       retry;
  logic       done;
  logic [1:0] done_err;
  logic       reject;
`ifdef FSM_CMD_FILTER_EN
  assign reject = bus.req_cmd[2:1] == 2'b11;
`else
  assign reject = 1'b0;
`endif
  always_comb begin
    exp_state = cmd_q[2] ? (cmd_q[0] ? 2'h1 : 2'h2) : 2'h3;
    exp_ok    = cmd_q[2:1] != 2'b11;
    match     = exp_ok ? bus.status_in[1:0] == exp_state : 1'b1;
    last      = rcnt == 3'(MAX_RETRIES);
    retry     = !last && tcnt == 8'(TIMEOUT_CYCLES - 1);
    done      = !bus.status_in[2] || match || (last && tcnt == 8'(TIMEOUT_CYCLES));
    done_err  = !bus.status_in[2] ? 2'b11 : match ? 2'b00 : 2'b10;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cmd_q          <= 3'h0;
      tcnt           <= 8'h0;
      rcnt           <= 3'h0;
      bus.req_ready  <= 1'b1;
      bus.cmd_out    <= 3'h0;
      bus.cmd_strobe <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_state  <= 2'h0;
      bus.rsp_err    <= 2'h0;
    end else begin
      case (state)
        IDLE: begin
          rcnt <= 3'h0;
          if (bus.req_valid) begin
            cmd_q         <= bus.req_cmd;
            bus.req_ready <= 1'b0;
            if (reject) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 2'b01;
              bus.rsp_state <= bus.status_in[1:0];
            end else begin
              state          <= ISSUE;
              bus.cmd_out    <= bus.req_cmd;
              bus.cmd_strobe <= 1'b1;
            end
          end
        end
        ISSUE: begin
          bus.cmd_strobe <= 1'b0;
          tcnt           <= 8'h0;
          state          <= WAIT;
        end
        WAIT: begin
          if (done) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= done_err;
            bus.rsp_state <= bus.status_in[1:0];
          end else if (retry) begin
            state          <= ISSUE;
            bus.cmd_out    <= cmd_q;
            bus.cmd_strobe <= 1'b1;
            rcnt           <= rcnt + 3'h1;
          end else if (tcnt != 8'hff) begin
            tcnt <= tcnt + 8'h1;
          end
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state          <= IDLE;
          cmd_q          <= 3'h0;
          tcnt           <= 8'h0;
          rcnt           <= 3'h0;
          bus.req_ready  <= 1'b1;
          bus.cmd_out    <= 3'h0;
          bus.cmd_strobe <= 1'b0;
          bus.rsp_valid  <= 1'b0;
          bus.rsp_state  <= 2'h0;
          bus.rsp_err    <= 2'h0;
        end
      endcase
    end
  end
endmodule
